// File: rtl/obstacle_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// obstacle_pkg
// Shared obstacle word layout, obstacle type encoding and scheduler FSM states.
// Obstacle word: [2:0] type, [4:3] lane, [7:5] zero, [15:8] row.
// -----------------------------------------------------------------------------
package obstacle_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        LOW   = 3'd1,
        HIGH  = 3'd2,
        MID   = 3'd3,
        TRAIN = 3'd4,
        RAMP  = 3'd5,
        CAR   = 3'd6
    } obstacle_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_RETIRE = 2'd2,
        ST_DECR   = 2'd3
    } sched_state_t;

    localparam int OBS_W    = 16;
    localparam int TYPE_LSB = 0;
    localparam int TYPE_W   = 3;
    localparam int LANE_LSB = 3;
    localparam int LANE_W   = 2;
    localparam int ROW_LSB  = 8;
    localparam int ROW_W    = 8;

    function automatic logic [ROW_W-1:0] get_row(input logic [OBS_W-1:0] obs);
        return obs[ROW_LSB +: ROW_W];
    endfunction

    function automatic logic [LANE_W-1:0] get_lane(input logic [OBS_W-1:0] obs);
        return obs[LANE_LSB +: LANE_W];
    endfunction

    function automatic obstacle_t get_type(input logic [OBS_W-1:0] obs);
        return obstacle_t'(obs[TYPE_LSB +: TYPE_W]);
    endfunction

endpackage

// File: rtl/obstacle_scheduler_ring_buffer.sv
// -----------------------------------------------------------------------------
// obstacle_ring_buffer
// Circular store of obstacle words with head/tail pointers and an entry count.
// Ports:
//   clk, rst            clock, synchronous active-high reset (empties buffer)
//   push_en, push_data  append a word at tail
//   pop_en              drop the word at head
//   rd_idx -> rd_data   combinational read of entry head+rd_idx
//   wr_en, wr_idx, wr_row  overwrite the row field of entry head+wr_idx
//   count               entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module obstacle_ring_buffer
    import obstacle_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_en,
    input  logic [OBS_W-1:0]           push_data,
    input  logic                       pop_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [OBS_W-1:0]           rd_data,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_idx,
    input  logic [ROW_W-1:0]           wr_row,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

    logic [OBS_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]    head_r;
    logic [AW-1:0]    tail_r;
    logic [CW-1:0]    count_r;
    logic [AW-1:0]    rd_addr_s;
    logic [AW-1:0]    wr_addr_s;

    // Pointer arithmetic wraps naturally at the power-of-two depth.
    assign rd_addr_s = head_r + rd_idx;
    assign wr_addr_s = head_r + wr_idx;
    assign rd_data   = mem_r[rd_addr_s];
    assign count     = count_r;

    // head/tail pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_en) begin
                tail_r <= tail_r + ONE_A;
            end
            if (pop_en) begin
                head_r <= head_r + ONE_A;
            end
            case ({push_en, pop_en})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // storage: pushes and row rewrites never coincide (different FSM states)
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_r[tail_r] <= push_data;
        end
        if (wr_en) begin
            mem_r[wr_addr_s][ROW_LSB +: ROW_W] <= wr_row;
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// -----------------------------------------------------------------------------
// obstacle_scheduler
// Buffers upcoming obstacles; on each frame streams them to game_logic one per
// cycle; on each half-block crossing of the score retires row-0 entries and
// moves the rest one row closer.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   new_frame         frame pulse (starts a scan)
//   game_over         freeze: pending work dropped, no new scans/advances
//   player_score      score, watched for HALF_BLOCK_LENGTH crossings
//   push_obstacle/push_valid/push_ready   producer handshake
//   obs_out/obs_valid/firstrow            scan beat stream
//   scan_done         pulse after the last beat
//   occupancy         entries held
//   overrun           sticky: a frame or row step was lost
// Optional build macro OBSTACLE_SCHEDULER_STATS_EN adds retired_count[15:0],
// a saturating count of retired obstacles.
// -----------------------------------------------------------------------------
module obstacle_scheduler
    import obstacle_pkg::*;
#(
    parameter int DEPTH             = 16,
    parameter int HALF_BLOCK_LENGTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    new_frame,
    input  logic                    game_over,
    input  logic [15:0]             player_score,
    input  logic [15:0]             push_obstacle,
    input  logic                    push_valid,
    output logic                    push_ready,
    output logic [15:0]             obs_out,
    output logic                    obs_valid,
    output logic                    firstrow,
    output logic                    scan_done,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    overrun
`ifdef OBSTACLE_SCHEDULER_STATS_EN
    ,
    output logic [15:0]             retired_count
`endif
);
    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = AW + 1;
    localparam int HB_SHIFT = $clog2(HALF_BLOCK_LENGTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    sched_state_t   state_r, state_nx_s;
    logic [CW-1:0]  idx_r, idx_nx_s;
    logic [CW-1:0]  count_s;
    logic           frame_pend_r, step_pend_r, overrun_r;
    logic [15:0]    sc_q_r;
    logic           step_s, push_en_s, pop_s, wr_en_s, beat_s, done_s;
    logic           enter_scan_s, enter_retire_s;
    logic [15:0]    rd_data_s;
    logic [7:0]     rd_row_s;
    logic [15:0]    obs_out_r;
    logic           obs_valid_r, firstrow_r, scan_done_r;

    obstacle_ring_buffer #(.DEPTH(DEPTH)) u_ring (
        .clk       (clk),
        .rst       (rst),
        .push_en   (push_en_s),
        .push_data (push_obstacle),
        .pop_en    (pop_s),
        .rd_idx    (idx_r[AW-1:0]),
        .rd_data   (rd_data_s),
        .wr_en     (wr_en_s),
        .wr_idx    (idx_r[AW-1:0]),
        .wr_row    (rd_row_s - 8'd1),
        .count     (count_s)
    );

    // push_ready must react to game_over in the same cycle, so it is decoded
    // directly from the state register, count and game_over.
    assign push_ready = (state_r == ST_IDLE) && (count_s < DEPTH_C) && !game_over;
    assign push_en_s  = push_valid && push_ready;
    assign step_s     = (player_score >> HB_SHIFT) != (sc_q_r >> HB_SHIFT);
    assign rd_row_s   = get_row(rd_data_s);

    assign obs_out    = obs_out_r;
    assign obs_valid  = obs_valid_r;
    assign firstrow   = firstrow_r;
    assign scan_done  = scan_done_r;
    assign occupancy  = count_s;
    assign overrun    = overrun_r;

    // next-state decode; idx walks the scan beats and the row-decrement pass
    always_comb begin
        state_nx_s     = state_r;
        idx_nx_s       = idx_r;
        pop_s          = 1'b0;
        wr_en_s        = 1'b0;
        beat_s         = 1'b0;
        done_s         = 1'b0;
        enter_scan_s   = 1'b0;
        enter_retire_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                idx_nx_s = ZERO_C;
                if (frame_pend_r && !game_over) begin
                    state_nx_s   = ST_SCAN;
                    enter_scan_s = 1'b1;
                end else if (step_pend_r && !game_over) begin
                    state_nx_s     = ST_RETIRE;
                    enter_retire_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (idx_r < count_s) begin
                    beat_s   = 1'b1;
                    idx_nx_s = idx_r + ONE_C;
                end else begin
                    done_s   = 1'b1;
                    idx_nx_s = ZERO_C;
                    if (step_pend_r && !game_over) begin
                        state_nx_s     = ST_RETIRE;
                        enter_retire_s = 1'b1;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
            end
            ST_RETIRE: begin
                // idx stays 0 here, so rd_data is the head entry
                if ((count_s != ZERO_C) && (rd_row_s == 8'd0)) begin
                    pop_s = 1'b1;
                end else begin
                    state_nx_s = ST_DECR;
                    idx_nx_s   = ZERO_C;
                end
            end
            ST_DECR: begin
                if (idx_r < count_s) begin
                    wr_en_s  = 1'b1;
                    idx_nx_s = idx_r + ONE_C;
                end else begin
                    state_nx_s = ST_IDLE;
                    idx_nx_s   = ZERO_C;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                idx_nx_s   = ZERO_C;
            end
        endcase
    end

    // FSM state and walk index
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= ZERO_C;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
        end
    end

    // score sample (loaded during reset so release does not fake a step),
    // pending flags and sticky overrun
    always_ff @(posedge clk) begin
        sc_q_r <= player_score;
        if (rst) begin
            frame_pend_r <= 1'b0;
            step_pend_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (game_over) begin
            frame_pend_r <= 1'b0;
            step_pend_r  <= 1'b0;
        end else begin
            // entering a state consumes its flag; an event landing while the
            // flag is still set is lost
            if ((new_frame && frame_pend_r) || (step_s && step_pend_r)) begin
                overrun_r <= 1'b1;
            end
            frame_pend_r <= enter_scan_s   ? 1'b0 : (frame_pend_r | new_frame);
            step_pend_r  <= enter_retire_s ? 1'b0 : (step_pend_r | step_s);
        end
    end

    // registered beat stream and scan_done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            obs_out_r   <= 16'h0000;
            obs_valid_r <= 1'b0;
            firstrow_r  <= 1'b0;
            scan_done_r <= 1'b0;
        end else begin
            obs_out_r   <= beat_s ? rd_data_s : 16'h0000;
            obs_valid_r <= beat_s;
            firstrow_r  <= beat_s && (rd_row_s == 8'd0);
            scan_done_r <= done_s;
        end
    end

`ifdef OBSTACLE_SCHEDULER_STATS_EN
    logic [15:0] retired_count_r;

    // saturating count of retired obstacles
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_count_r <= 16'h0000;
        end else if (pop_s && (retired_count_r != 16'hFFFF)) begin
            retired_count_r <= retired_count_r + 16'd1;
        end else begin
            retired_count_r <= retired_count_r;
        end
    end

    assign retired_count = retired_count_r;
`endif

endmodule

// File: tb/tb_obstacle_scheduler.sv
// -----------------------------------------------------------------------------
// tb_obstacle_scheduler
// Directed scenarios followed by random stimulus. A transaction-level model
// (queue of obstacle words plus per-phase cycle budgets) predicts the DUT
// outputs; one compare process checks them on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_obstacle_scheduler;

    logic        clk;
    logic        rst;
    logic        new_frame;
    logic        game_over;
    logic [15:0] player_score;
    logic [15:0] push_obstacle;
    logic        push_valid;
    logic        push_ready;
    logic [15:0] obs_out;
    logic        obs_valid;
    logic        firstrow;
    logic        scan_done;
    logic [4:0]  occupancy;
    logic        overrun;
`ifdef OBSTACLE_SCHEDULER_STATS_EN
    logic [15:0] retired_count;
`endif

    obstacle_scheduler #(.DEPTH(16), .HALF_BLOCK_LENGTH(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .new_frame     (new_frame),
        .game_over     (game_over),
        .player_score  (player_score),
        .push_obstacle (push_obstacle),
        .push_valid    (push_valid),
        .push_ready    (push_ready),
        .obs_out       (obs_out),
        .obs_valid     (obs_valid),
        .firstrow      (firstrow),
        .scan_done     (scan_done),
        .occupancy     (occupancy),
        .overrun       (overrun)
`ifdef OBSTACLE_SCHEDULER_STATS_EN
        ,
        .retired_count (retired_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_ph: 0 idle, 1 scanning, 2 retiring, 3 decrementing
    logic [15:0] mq[$];
    logic [16:0] script[$];   // scan outputs still to appear: bit16=done marker
    int          m_ph = 0;
    int          m_rem = 0;
    logic        m_fp = 1'b0, m_sp = 1'b0, m_ov = 1'b0;
    logic [15:0] m_scq = 16'h0000;
    logic        e_valid = 1'b0, e_first = 1'b0, e_done = 1'b0;
    logic [15:0] e_obs = 16'h0000;
    bit          model_live = 1'b0;

    task automatic start_retire();
        int k = 0;
        while (mq.size() > 0 && mq[0][15:8] == 8'd0) begin
            void'(mq.pop_front());
            k++;
        end
        m_ph  = 2;
        m_rem = k + 1;
    endtask

    task automatic model_step();
        logic        ofp, osp, stp, es, er;
        logic [16:0] it;
        logic [15:0] tmp;
        if (rst) begin
            mq.delete(); script.delete();
            m_ph = 0; m_rem = 0; m_fp = 1'b0; m_sp = 1'b0; m_ov = 1'b0;
            m_scq = player_score;
            e_valid = 1'b0; e_first = 1'b0; e_done = 1'b0; e_obs = 16'h0000;
            return;
        end
        ofp = m_fp; osp = m_sp; es = 1'b0; er = 1'b0;
        stp = (player_score / 16'd64) != (m_scq / 16'd64);
        m_scq = player_score;
        e_valid = 1'b0; e_first = 1'b0; e_done = 1'b0; e_obs = 16'h0000;
        case (m_ph)
            0: begin
                if (push_valid && mq.size() < 16 && !game_over) mq.push_back(push_obstacle);
                if (ofp && !game_over) begin
                    m_ph = 1; es = 1'b1;
                    script.delete();
                    foreach (mq[i]) script.push_back({1'b0, mq[i]});
                    script.push_back(17'h10000);
                end else if (osp && !game_over) begin
                    start_retire(); er = 1'b1;
                end
            end
            1: begin
                it = script.pop_front();
                if (it[16]) begin
                    e_done = 1'b1;
                    if (osp && !game_over) begin start_retire(); er = 1'b1; end
                    else m_ph = 0;
                end else begin
                    e_valid = 1'b1; e_obs = it[15:0]; e_first = (it[15:8] == 8'd0);
                end
            end
            2: begin
                m_rem--;
                if (m_rem == 0) begin
                    for (int i = 0; i < mq.size(); i++) begin
                        tmp = mq[i]; tmp[15:8] = tmp[15:8] - 8'd1; mq[i] = tmp;
                    end
                    m_ph = 3; m_rem = mq.size() + 1;
                end
            end
            default: begin
                m_rem--;
                if (m_rem == 0) m_ph = 0;
            end
        endcase
        if (game_over) begin
            m_fp = 1'b0; m_sp = 1'b0;
        end else begin
            if ((new_frame && ofp) || (stp && osp)) m_ov = 1'b1;
            m_fp = es ? 1'b0 : (ofp | new_frame);
            m_sp = er ? 1'b0 : (osp | stp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        model_live = 1'b1;
    end

    // ---------------- compare process ----------------
    logic [16:0] seen[$];
    int          beat_cyc[$];
    int          done_cnt = 0;
    int          last_done = 0;
    int          cyc_no = 0;

    initial forever begin
        @(negedge clk);
        cyc_no++;
        if (model_live) begin
            chk("obs_valid", {31'd0, obs_valid}, {31'd0, e_valid});
            chk("obs_out",   {16'd0, obs_out},   {16'd0, e_obs});
            chk("firstrow",  {31'd0, firstrow},  {31'd0, e_first});
            chk("scan_done", {31'd0, scan_done}, {31'd0, e_done});
            chk("overrun",   {31'd0, overrun},   {31'd0, m_ov});
            chk("push_ready", {31'd0, push_ready},
                {31'd0, (m_ph == 0 && mq.size() < 16 && !game_over)});
            if (m_ph == 0) chk("occupancy", {27'd0, occupancy}, mq.size());
            if (obs_valid) begin
                seen.push_back({firstrow, obs_out});
                beat_cyc.push_back(cyc_no);
            end
            if (scan_done) begin
                done_cnt++;
                last_done = cyc_no;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push_one(input logic [15:0] w);
        push_valid = 1'b1; push_obstacle = w;
        cyc();
        push_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        new_frame = 1'b1;
        cyc();
        new_frame = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            if (m_ph == 0 && !m_fp && !m_sp) return;
            cyc();
        end
        chk({name, "_idle_timeout"}, 32'd1, 32'd0);
    endtask

    int busy;

    initial begin
        rst = 1'b1; new_frame = 1'b0; game_over = 1'b0; player_score = 16'd0;
        push_obstacle = 16'h0000; push_valid = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        // reset state
        chk("rst_push_ready", {31'd0, push_ready}, 32'd1);
        chk("rst_occupancy", {27'd0, occupancy}, 32'd0);
        chk("rst_outputs", {28'd0, obs_valid, firstrow, scan_done, overrun}, 32'd0);

        // T1: rows 0,2,5 then a frame
        push_one(16'h0001); push_one(16'h020A); push_one(16'h0513);
        seen.delete(); beat_cyc.delete(); done_cnt = 0;
        pulse_frame();
        wait_idle("t1"); cyc();
        chk("t1_beats", seen.size(), 32'd3);
        if (seen.size() == 3) begin
            chk("t1_beat0", {15'd0, seen[0]}, 32'h10001);
            chk("t1_beat1", {15'd0, seen[1]}, 32'h0020A);
            chk("t1_beat2", {15'd0, seen[2]}, 32'h00513);
            chk("t1_done_next", last_done, beat_cyc[2] + 1);
        end
        chk("t1_done_cnt", done_cnt, 32'd1);

        // T2: score 63 -> 64 retires row 0, rows become 1,4
        player_score = 16'd63; cyc();
        player_score = 16'd64; cyc();
        wait_idle("t2");
        chk("t2_occupancy", {27'd0, occupancy}, 32'd2);
        chk("t2_model_rows", {16'd0, mq[0][15:8], mq[1][15:8]}, 32'h0104);
        seen.delete();
        pulse_frame(); wait_idle("t2s"); cyc();
        chk("t2_rescan", seen.size(), 32'd2);
        if (seen.size() == 2) begin
            chk("t2_rows0", {15'd0, seen[0]}, 32'h0010A);
            chk("t2_rows1", {15'd0, seen[1]}, 32'h00413);
        end

        // T3: fill to 16, refuse the 17th, free space with two steps
        for (int i = 0; i < 14; i++) push_one({8'd10, 3'b000, 2'(i), 3'(i % 7)});
        chk("t3_full_ready", {31'd0, push_ready}, 32'd0);
        chk("t3_full_occ", {27'd0, occupancy}, 32'd16);
        push_one(16'h0A01);
        chk("t3_refused", {27'd0, occupancy}, 32'd16);
        player_score = 16'd128; cyc(); wait_idle("t3a");
        player_score = 16'd192; cyc(); wait_idle("t3b");
        chk("t3_freed_occ", {27'd0, occupancy}, 32'd15);
        chk("t3_freed_ready", {31'd0, push_ready}, 32'd1);

        // T4: extra frames during a long scan -> one follow-up, overrun
        seen.delete(); done_cnt = 0;
        pulse_frame();
        repeat (3) cyc();
        pulse_frame();
        repeat (3) cyc();
        pulse_frame();
        wait_idle("t4"); cyc();
        chk("t4_done_cnt", done_cnt, 32'd2);
        chk("t4_beats", seen.size(), 32'd30);
        chk("t4_overrun", {31'd0, overrun}, 32'd1);

        // T5: frame and step together -> scan, retire, decr back to back
        rst = 1'b1; cyc(); rst = 1'b0;
        push_one(16'h0001); push_one(16'h0302);
        player_score = 16'd256; new_frame = 1'b1; cyc(); new_frame = 1'b0;
        busy = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (!push_ready) busy++;
            else if (busy > 0) break;
        end
        chk("t5_busy_cycles", busy, 32'd7);
        chk("t5_occupancy", {27'd0, occupancy}, 32'd1);

        // T6: game_over freezes everything
        game_over = 1'b1; cyc();
        chk("t6_ready", {31'd0, push_ready}, 32'd0);
        seen.delete();
        pulse_frame();
        push_valid = 1'b1; push_obstacle = 16'h0001;
        repeat (10) cyc();
        push_valid = 1'b0;
        chk("t6_no_beats", seen.size(), 32'd0);
        chk("t6_held", {27'd0, occupancy}, 32'd1);
        game_over = 1'b0; cyc();

        // T7: reset in the middle of the decrement pass
        for (int i = 0; i < 6; i++) push_one(16'h0102);
        player_score = 16'd320; cyc();
        repeat (3) cyc();
        chk("t7_in_decr", m_ph, 32'd3);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("t7_emptied", {27'd0, occupancy}, 32'd0);

        // random phase
        for (int i = 0; i < 4000; i++) begin
            new_frame = ($urandom % 16) == 0;
            if (($urandom % 200) == 0) game_over = ~game_over;
            push_valid = $urandom % 2;
            push_obstacle = {8'($urandom % 4), 3'b000, 2'($urandom), 3'($urandom % 7)};
            if (($urandom % 6) == 0) player_score = player_score + 16'($urandom_range(0, 50));
            rst = ($urandom % 700) == 0;
            cyc();
        end
        rst = 1'b0; new_frame = 1'b0; push_valid = 1'b0; game_over = 1'b0;
        repeat (60) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
